lsnn_spike_aer: RTL and testbench
=================================

LSNN_SPIKE_AER -- requirements
Module: lsnn_spike_aer

Interface
REQ-001: Parameter DEPTH, 4, event FIFO depth in entries (power of two, 2..16).
REQ-002: Parameter WIN_LOG2, 4, log2 of the spike-rate window length in cycles.
REQ-003: The block SHALL use one clock; reset is synchronous and active-high.
REQ-004: clk  input  1  clock; all state updates on rising edge.
REQ-005: rst_n  input  1  synchronous active-high reset.
REQ-006: ena  input  1  capture enable; 0 suppresses event capture and rate counting.
REQ-007: spike_in  input  1  spike flag from the LSNN neuron, bit 0 of its output.
REQ-008: thr_in  input  8  neuron threshold presented in the same cycle as spike_in.
REQ-009: out_data  output  8  serialized event byte.
REQ-010: out_valid  output  1  out_data holds a valid byte.
REQ-011: out_last  output  1  marks the second (final) byte of an event.
REQ-012: out_ready  input  1  consumer accepts the byte when out_valid && out_ready.
REQ-013: overflow  output  1  sticky flag, set when an event was dropped.
REQ-014: drop_cnt  output  8  count of dropped events, saturating at 255.
REQ-015: fifo_level  output  $clog2(DEPTH)+1  current number of FIFO entries.
REQ-016: rate_out  output  8  spike count of the last completed window.

Function
REQ-017: An 8-bit free-running timestamp SHALL increment every cycle, wrapping from 255 to 0, independent of ena.
REQ-018: An event SHALL be the 16-bit pair {timestamp, thr_in}, captured in any cycle with ena=1 and spike_in=1.
REQ-019: A captured event SHALL be pushed to the FIFO if it is not full, or if a pop occurs in the same cycle.
REQ-020: Otherwise the event SHALL be dropped, overflow set to 1, and drop_cnt incremented with saturation at 255.
REQ-021: The serializer FSM SHALL have the states IDLE, SEND_TS and SEND_THR.
REQ-022: IDLE with FIFO non-empty: pop into a holding register, go to SEND_TS; out_valid rises the next cycle.
REQ-023: SEND_TS: out_valid=1, out_data=timestamp, out_last=0; on handshake go to SEND_THR.
REQ-024: SEND_THR: out_valid=1, out_data=threshold, out_last=1; on handshake pop and go to SEND_TS if FIFO non-empty, else go to IDLE.
REQ-025: While out_valid=1 and out_ready=0, out_data and out_last SHALL remain stable.
REQ-026: Minimum latency from spike_in to the first out_valid SHALL be 2 cycles (push, then pop).
REQ-027: Sustained throughput SHALL be one event per 2 cycles with no idle cycle between events.
REQ-028: fifo_level SHALL reflect the registered push/pop result and never exceed DEPTH; a simultaneous push and pop leaves it unchanged.
REQ-029: A window counter SHALL count 2^WIN_LOG2 cycles while ena=1.
REQ-030: In the last cycle of each window, rate_out SHALL load the window count including that cycle's spike, and the count SHALL restart at 0.
REQ-031: The window spike count SHALL saturate at 255.
REQ-032: ena=0 SHALL freeze the window counter and spike count; serialization of queued events SHALL continue.

Reset
REQ-033: On rst_n=1 at a clock edge, the following SHALL clear: timestamp, FIFO pointers, fifo_level, FSM (to IDLE), out_valid, out_last, out_data, overflow, drop_cnt, window counter, and rate_out.
REQ-034: A reset mid-event SHALL discard the partially sent event; out_valid is 0 in the cycle after reset.
REQ-035: overflow SHALL clear only by reset.

Structure
REQ-036: A shared package SHALL hold the FSM state enum, the event width (16), the timestamp width (8) and the saturation constant 255.
REQ-037: The FIFO SHALL be a separate sub-module, lsnn_event_fifo, with push/pop/full/empty/level ports and no read latency on its head entry.

Verification
REQ-038: Reset, then a single spike at timestamp 5 with thr_in=0x10 and out_ready=1 -> bytes 0x05 (last=0) then 0x10 (last=1), then out_valid=0.
REQ-039: out_ready=0 for 10 cycles during SEND_TS -> out_data holds 0x05 and out_valid stays 1; the event completes after ready returns.
REQ-040: 7 consecutive spikes with out_ready=0 and DEPTH=4 -> fifo_level=4 and the holding register is occupied, drop_cnt=2, overflow=1.
REQ-041: spike_in=1 every cycle with ena=1 and WIN_LOG2=4 -> rate_out=16 after the first window; ena=0 for 5 cycles delays the update by 5 cycles.
REQ-042: Reset asserted during SEND_THR -> out_valid=0, fifo_level=0 and the FSM in IDLE on the next cycle.
REQ-043: Timestamp wrap with spikes at cycles 254, 255 and 256 -> emitted timestamps 0xFE, 0xFF and 0x00.

Source files
------------

// File: rtl/lsnn_spike_aer_pkg.sv
// Shared types and constants for the LSNN spike AER serializer.
package lsnn_spike_aer_pkg;

  localparam int unsigned EVT_W = 16;
  localparam int unsigned TS_W  = 8;
  localparam logic [7:0]  SAT_MAX = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_TS,
    ST_SEND_THR
  } aer_state_t;

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [7:0]      thr;
  } aer_event_t;

  // Increment by one when inc is set, holding at SAT_MAX.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic inc);
    return (inc && (a != SAT_MAX)) ? a + 8'd1 : a;
  endfunction

endpackage

// File: rtl/lsnn_event_fifo.sv
// Event FIFO with combinational head output (no read latency).
module lsnn_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          do_push, do_pop;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr_q];
  assign level    = level_q;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  // Pointer and occupancy update; simultaneous push and pop keep the level.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_q <= level_q + LW'(1);
      else if (do_pop && !do_push) level_q <= level_q - LW'(1);
    end
  end

endmodule

// File: rtl/lsnn_spike_aer.sv
// Spike event capture, FIFO queueing, two-byte AER serialization and rate window.
module lsnn_spike_aer
  import lsnn_spike_aer_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned WIN_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   spike_in,
  input  logic [7:0]             thr_in,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             rate_out
);

  aer_state_t          state_q, state_d;
  aer_event_t          hold_q, fifo_head, push_evt;
  logic [TS_W-1:0]     ts_q;
  logic                capture, fifo_pop, load_hold, drop;
  logic                fifo_full, fifo_empty;
  logic [WIN_LOG2-1:0] win_q;
  logic [7:0]          spk_q, spk_next;

  assign capture  = ena && spike_in;
  assign push_evt = '{ts: ts_q, thr: thr_in};
  assign drop     = capture && fifo_full && !fifo_pop;

  lsnn_event_fifo #(
    .DEPTH (DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (capture),
    .push_data (push_evt),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Free-running timestamp, independent of ena.
  always_ff @(posedge clk) begin
    if (rst_n) ts_q <= '0;
    else       ts_q <= ts_q + 8'd1;
  end

  // Serializer state and holding register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_hold) hold_q <= fifo_head;
    end
  end

  // Serializer next state; SEND_THR chains straight into the next event.
  always_comb begin
    state_d   = state_q;
    fifo_pop  = 1'b0;
    load_hold = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          load_hold = 1'b1;
          state_d   = ST_SEND_TS;
        end
      end
      ST_SEND_TS: begin
        if (out_ready) state_d = ST_SEND_THR;
      end
      ST_SEND_THR: begin
        if (out_ready) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            load_hold = 1'b1;
            state_d   = ST_SEND_TS;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output byte selection from the held event.
  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    unique case (state_q)
      ST_SEND_TS: begin
        out_valid = 1'b1;
        out_data  = hold_q.ts;
      end
      ST_SEND_THR: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = hold_q.thr;
      end
      default: ;
    endcase
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= sat_add8(drop_cnt, 1'b1);
    end
  end

  assign spk_next = sat_add8(spk_q, spike_in);

  // Spike-rate window; frozen while ena is low.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      win_q    <= '0;
      spk_q    <= '0;
      rate_out <= '0;
    end else if (ena) begin
      win_q <= win_q + WIN_LOG2'(1);
      if (&win_q) begin
        rate_out <= spk_next;
        spk_q    <= '0;
      end else begin
        spk_q <= spk_next;
      end
    end
  end

endmodule

// File: tb/tb_lsnn_spike_aer.sv
// Directed self-checking bench for lsnn_spike_aer.
module tb_lsnn_spike_aer;

  logic       clk = 1'b0;
  logic       rst_n, ena, spike_in, out_ready;
  logic [7:0] thr_in;
  logic [7:0] out_data, drop_cnt, rate_out;
  logic       out_valid, out_last, overflow;
  logic [2:0] fifo_level;

  int total = 0;
  int bad   = 0;

  lsnn_spike_aer #(
    .DEPTH    (4),
    .WIN_LOG2 (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .spike_in   (spike_in),
    .thr_in     (thr_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level),
    .rate_out   (rate_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hold reset across one rising edge; returns at a falling edge with reset released.
  // At return the timestamp is 0 and will read 1 after the next rising edge.
  task automatic do_reset();
    rst_n     = 1'b1;
    ena       = 1'b1;
    spike_in  = 1'b0;
    thr_in    = 8'h00;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  int         n_ts, n_thr;
  logic [7:0] ts_seen [3];
  logic [7:0] thr_seen[3];

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_last", out_last, 0);
    check_eq("rst_data", out_data, 0);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_drop", drop_cnt, 0);
    check_eq("rst_rate", rate_out, 0);

    // Single spike at timestamp 5
    repeat (5) @(negedge clk);
    spike_in = 1'b1; thr_in = 8'h10;
    @(negedge clk);
    spike_in = 1'b0;
    check_eq("t1_level_after_push", fifo_level, 1);
    check_eq("t1_valid_lat1", out_valid, 0);
    @(negedge clk);
    check_eq("t1_valid_ts", out_valid, 1);
    check_eq("t1_data_ts", out_data, 8'h05);
    check_eq("t1_last_ts", out_last, 0);
    @(negedge clk);
    check_eq("t1_data_thr", out_data, 8'h10);
    check_eq("t1_last_thr", out_last, 1);
    @(negedge clk);
    check_eq("t1_valid_end", out_valid, 0);

    // Backpressure in SEND_TS
    do_reset();
    out_ready = 1'b0;
    repeat (5) @(negedge clk);
    spike_in = 1'b1; thr_in = 8'h10;
    @(negedge clk);
    spike_in = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check_eq("t2_hold_valid", out_valid, 1);
      check_eq("t2_hold_data", out_data, 8'h05);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("t2_data_thr", out_data, 8'h10);
    check_eq("t2_last_thr", out_last, 1);
    @(negedge clk);
    check_eq("t2_valid_end", out_valid, 0);

    // Overflow: 7 spikes, consumer stalled
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      spike_in = 1'b1; thr_in = 8'h20 + 8'(i);
      @(negedge clk);
    end
    spike_in = 1'b0;
    check_eq("t3_level", fifo_level, 4);
    check_eq("t3_drop", drop_cnt, 2);
    check_eq("t3_ovf", overflow, 1);
    check_eq("t3_hold_valid", out_valid, 1);
    check_eq("t3_hold_ts", out_data, 8'h00);
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("t3_drain_level", fifo_level, 0);
    check_eq("t3_drain_valid", out_valid, 0);
    check_eq("t3_ovf_sticky", overflow, 1);
    check_eq("t3_drop_keep", drop_cnt, 2);

    // Rate window: full window of spikes, then a window of 3 spikes with a 5-cycle ena gap
    do_reset();
    spike_in = 1'b1;
    repeat (15) @(negedge clk);
    check_eq("t4_rate_before", rate_out, 0);
    @(negedge clk);
    check_eq("t4_rate_win1", rate_out, 16);
    repeat (3) @(negedge clk);
    spike_in = 1'b0;
    repeat (5) @(negedge clk);
    ena = 1'b0; spike_in = 1'b1;
    repeat (5) @(negedge clk);
    ena = 1'b1; spike_in = 1'b0;
    repeat (7) @(negedge clk);
    check_eq("t4_rate_delayed", rate_out, 16);
    @(negedge clk);
    check_eq("t4_rate_win2", rate_out, 3);

    // Reset during SEND_THR with a queued event
    do_reset();
    repeat (3) @(negedge clk);
    spike_in = 1'b1; thr_in = 8'h33;
    @(negedge clk);
    thr_in = 8'h44;
    @(negedge clk);
    spike_in = 1'b0;
    @(negedge clk);
    check_eq("t5_in_thr", out_last, 1);
    check_eq("t5_queued", fifo_level, 1);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    check_eq("t5_valid", out_valid, 0);
    check_eq("t5_level", fifo_level, 0);
    check_eq("t5_last", out_last, 0);
    @(negedge clk);
    check_eq("t5_idle", out_valid, 0);

    // Timestamp wrap: spikes at timestamps 254, 255, 0
    do_reset();
    repeat (254) @(negedge clk);
    n_ts = 0; n_thr = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid && out_ready) begin
        if (!out_last) begin
          if (n_ts < 3) ts_seen[n_ts] = out_data;
          n_ts++;
        end else begin
          if (n_thr < 3) thr_seen[n_thr] = out_data;
          n_thr++;
        end
      end
      spike_in = (i < 3);
      thr_in   = 8'hA1 + 8'(i);
      @(negedge clk);
    end
    check_eq("t6_n_ts", n_ts, 3);
    check_eq("t6_n_thr", n_thr, 3);
    if (n_ts >= 3) begin
      check_eq("t6_ts0", ts_seen[0], 8'hFE);
      check_eq("t6_ts1", ts_seen[1], 8'hFF);
      check_eq("t6_ts2", ts_seen[2], 8'h00);
    end
    if (n_thr >= 3) begin
      check_eq("t6_thr0", thr_seen[0], 8'hA1);
      check_eq("t6_thr2", thr_seen[2], 8'hA3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
